muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for the MIPS multiply/divide instructions (mult, multu, div, divu). It replaces the combinational MUL/DIV paths feeding HILO. It captures operands when a muldiv instruction is decoded and runs a 32-iteration shift-add multiply or restoring divide. While it runs it holds the CPU with a stall line, then issues a one-cycle HILO write with the result.

## Interface
Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  global CPU enable; when low, all state is frozen.
- start  in  1  level; high while the current instruction is a muldiv op.
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  Rs operand (multiplicand/dividend).
- b  in  WIDTH  Rt operand (multiplier/divisor).
- stall  out  1  holds PC and register file while high; combinational.
- hilo_we  out  1  one-cycle HILO write strobe.
- hi_out  out  WIDTH  product[63:32] or remainder.
- lo_out  out  WIDTH  product[31:0] or quotient.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE, count=0, stall=0, hilo_we=0, hi_out=0, lo_out=0.
- IDLE with start=1:
  - capture op, sign of a (sa) and sign of b (sb);
  - capture magnitudes |a| and |b| for signed ops, raw values for unsigned ops;
  - go to RUN with count=0.
- IDLE with start=1, op a divide and b==0: go directly to DONE with HI=a and LO=32'hFFFF_FFFF. This applies to both div and divu.
- RUN executes one iteration per enabled cycle:
  - multiply: 64-bit shift-add on the magnitudes;
  - divide: restoring, one quotient bit per cycle, MSB first.
  - At count==WIDTH-1, go to DONE.
- DONE:
  - Apply signed fixup.
    - mult: negate the product when sa^sb.
    - div: negate the quotient when sa^sb; negate the remainder when sa.
  - Load hi_out and lo_out, pulse hilo_we, return to IDLE.
- Arithmetic is two's complement modulo 2^WIDTH. 0x8000_0000 / -1 yields LO=0x8000_0000, HI=0.
- start is sampled only in IDLE. A start held high during RUN/DONE never restarts the operation.
- hi_out and lo_out hold their last result until the next DONE.
- stall = (state==IDLE & start) | (state==RUN). stall is low in DONE, so the PC advances on the same edge that writes HILO.
- ena=0: state, count, datapath and outputs all hold; hilo_we is forced to 0. A pending DONE completes on the next ena=1 cycle.
- rst_n=0 mid-operation: return to IDLE on that edge, with no HILO write and stall low from the next cycle.

## Timing
- Cycle 0 is the IDLE cycle in which start is seen, with stall high combinationally.
- Normal op:
  - RUN occupies cycles 1..32;
  - DONE is cycle 33, with hilo_we=1 and results valid on hi_out/lo_out the same cycle;
  - stall is high for cycles 0..32, 33 cycles total.
- Divide by zero: stall is high in cycle 0 only; DONE and hilo_we fall in cycle 1.
- Back-to-back muldiv: the next instruction's start is seen in the IDLE cycle after DONE, with no idle gap beyond that.
- Each ena-low cycle extends latency by exactly one cycle.

## Structure
- muldiv_pkg holds:
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - the state encoding IDLE/RUN/DONE;
  - MD_ITER=32.
- One sub-module, muldiv_step, provides the combinational single iteration: given the partial accumulator, operand and op class, it returns the next accumulator. The top module holds the FSM, counter, sign flags and fixup.
- CPU integration:
  - start decodes from is_mult | is_multu | is_div | is_divu;
  - stall gates the PC/Regfile enable;
  - hilo_we ORs into the HI/LO write enables with hi_out/lo_out muxed into HI_in/LO_in.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF, start held -> stall for 33 cycles; cycle 33: hilo_we=1, HI=0xFFFFFFFE, LO=0x00000001.
- mult a=-3, b=5 -> cycle 33: HI=0xFFFFFFFF, LO=0xFFFFFFF1. Repeat with a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0.
- div a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=100, b=7 -> LO=14, HI=2. div 0x80000000/-1 -> LO=0x80000000, HI=0.
- divu a=100, b=0 -> stall only in cycle 0; cycle 1: hilo_we=1, HI=0x64, LO=0xFFFFFFFF.
- ena=0 for 5 cycles during RUN -> hilo_we at cycle 38 with results identical to the ena-always-high run. rst_n=0 at cycle 10 -> no hilo_we, stall=0, outputs 0.
- Two consecutive muldiv instructions with start continuously high -> exactly two hilo_we pulses, 34 cycles apart, each with correct results; no spurious restart during RUN.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the multiply/divide sequencer
package muldiv_pkg;

    localparam int MD_ITER = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - CPU to muldiv sequencer request/result bundle
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             hilo_we;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a, b,
        input  stall, hilo_we, hi_out, lo_out
    );

    modport slave (
        input  start, op, a, b,
        output stall, hilo_we, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;

    // acc = {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        hi    = acc_i[2*WIDTH-1:WIDTH];
        lo    = acc_i[WIDTH-1:0];
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        trial = {hi, lo[WIDTH-1]} - {1'b0, opnd_i};
        if (is_div_i) begin
            if (!trial[WIDTH]) begin
                acc_o = {trial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {hi[WIDTH-2:0], lo[WIDTH-1], lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle mult/multu/div/divu sequencer driving HILO
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    muldiv_seq_if.slave md
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e          state_q;
    logic [CW-1:0]      count_q;
    logic [1:0]         op_q;
    logic               sa_q;
    logic               sb_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               in_signed;
    logic               in_div;
    logic               in_sa;
    logic               in_sb;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        in_signed = ~md.op[0];
        in_div    = md.op[1];
        in_sa     = in_signed & md.a[WIDTH-1];
        in_sb     = in_signed & md.b[WIDTH-1];
        mag_a     = in_sa ? -md.a : md.a;
        mag_b     = in_sb ? -md.b : md.b;
        div_zero  = in_div & (md.b == '0);
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (op_q[1]),
        .acc_o    (acc_step)
    );

    // Sign fixup is applied to the final iteration's result as it is latched
    always_comb begin
        prod_fix = (op_q == MD_MULT && (sa_q ^ sb_q)) ? -acc_step : acc_step;
        quot_fix = (op_q == MD_DIV && (sa_q ^ sb_q)) ? -acc_step[WIDTH-1:0]
                                                      : acc_step[WIDTH-1:0];
        rem_fix  = (op_q == MD_DIV && sa_q) ? -acc_step[2*WIDTH-1:WIDTH]
                                            : acc_step[2*WIDTH-1:WIDTH];
        if (op_q[1]) begin
            fix_hi = rem_fix;
            fix_lo = quot_fix;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= MD_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (md.start) begin
                        op_q    <= md.op;
                        sa_q    <= in_sa;
                        sb_q    <= in_sb;
                        count_q <= '0;
                        if (div_zero) begin
                            hi_q    <= md.a;
                            lo_q    <= '1;
                            state_q <= DONE;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                            opnd_q  <= in_div ? mag_b : mag_a;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q   <= acc_step;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        hi_q    <= fix_hi;
                        lo_q    <= fix_lo;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign md.stall   = ((state_q == IDLE) & md.start) | (state_q == RUN);
    assign md.hilo_we = (state_q == DONE) & ena;
    assign md.hi_out  = hi_q;
    assign md.lo_out  = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq
module tb_muldiv_seq;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ena;
    int          cyc;
    int          total;
    int          bad;
    exp_t        sb[$];
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    muldiv_seq_if #(.WIDTH(32)) md();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .md    (md)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operand values
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t            e;
        longint          sx;
        longint          sy;
        longint          p;
        longint          q;
        longint          r;
        longint unsigned ux;
        longint unsigned uy;
        longint unsigned up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        e.cyc = 0;
        if (o[1] && y == 32'd0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
        end else if (o == MD_MULT) begin
            p    = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (o == MD_MULTU) begin
            up   = ux * uy;
            e.hi = up[63:32];
            e.lo = up[31:0];
        end else if (o == MD_DIV) begin
            q    = sx / sy;
            r    = sx % sy;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end else begin
            up   = ux / uy;
            q    = longint'(ux % uy);
            e.hi = q[31:0];
            e.lo = up[31:0];
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (md.hilo_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_hilo_we", {63'd0, md.hilo_we}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi_out", {32'd0, md.hi_out}, {32'd0, e.hi});
                check("lo_out", {32'd0, md.lo_out}, {32'd0, e.lo});
                check("we_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // CPU-like driver: instruction retires on the first enabled cycle with stall low
    task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          input int gs, input int gl);
        exp_t e;
        int   base;
        int   stalls;
        int   rel;
        bit   done;
        e     = model(o, xa, xb);
        base  = (o[1] && xb == 32'd0) ? 1 : 33;
        e.cyc = cyc + base + gl;
        sb.push_back(e);
        md.start = 1'b1;
        md.op    = o;
        md.a     = xa;
        md.b     = xb;
        stalls   = 0;
        rel      = 0;
        done     = 1'b0;
        while (!done && rel < 200) begin
            ena = !(gl > 0 && rel >= gs && rel < gs + gl);
            @(negedge clk);
            if (rel == 0) begin
                check("hold_hi", {32'd0, md.hi_out}, {32'd0, prev_hi});
                check("hold_lo", {32'd0, md.lo_out}, {32'd0, prev_lo});
            end
            if (md.stall) stalls++;
            if (!md.stall && ena) done = 1'b1;
            @(posedge clk);
            #1;
            rel++;
        end
        ena = 1'b1;
        check("op_retired", {63'd0, done}, 64'd1);
        check("stall_cycles", 64'(stalls), 64'(base + ((gs < base) ? gl : 0)));
        prev_hi = e.hi;
        prev_lo = e.lo;
    endtask

    task automatic idle(input int n);
        md.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_stall", {63'd0, md.stall}, 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        ena      = 1'b1;
        rst_n    = 1'b0;
        md.start = 1'b0;
        md.op    = MD_MULT;
        md.a     = 32'd0;
        md.b     = 32'd0;
        prev_hi  = 32'd0;
        prev_lo  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_stall", {63'd0, md.stall}, 64'd0);
        check("reset_we", {63'd0, md.hilo_we}, 64'd0);
        check("reset_hi", {32'd0, md.hi_out}, 64'd0);
        check("reset_lo", {32'd0, md.lo_out}, 64'd0);
        @(posedge clk);
        #1;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,         0, 0);
        run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0);
        run_op(MD_DIVU,  32'd100,       32'd7,         0, 0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        idle(1);
        run_op(MD_DIVU,  32'd100,       32'd0,         0, 0);
        run_op(MD_DIV,   32'hFFFF_FFFB, 32'd0,         0, 0);
        idle(2);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 5);
        run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,         33, 2);
        run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 0, 0);

        for (int n = 0; n < 24; n++) begin
            logic [1:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            int          gs;
            int          gl;
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 9));
                2: x = 32'h8000_0000;
                default: ;
            endcase
            gs = 0;
            gl = 0;
            if (!(o[1] && y == 32'd0) && $urandom_range(0, 2) == 0) begin
                gs = int'($urandom_range(1, 33));
                gl = int'($urandom_range(1, 4));
            end
            run_op(o, x, y, gs, gl);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end

        md.start = 1'b1;
        md.op    = MD_MULT;
        md.a     = 32'h1234_5678;
        md.b     = 32'h9ABC_DEF0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b0;
        md.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_stall", {63'd0, md.stall}, 64'd0);
        check("abort_hi", {32'd0, md.hi_out}, 64'd0);
        check("abort_lo", {32'd0, md.lo_out}, 64'd0);
        @(posedge clk);
        #1;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        idle(40);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
